// File: rtl/lvds_fwd_pkg.sv
// Shared definitions for the LVDS clock-forwarding controller: state encoding,
// counter width and default phase lengths.
package lvds_fwd_pkg;

  localparam int unsigned CNT_W           = 16;
  localparam int unsigned STARTUP_CYC_DEF = 16;
  localparam int unsigned TRAIN_CYC_DEF   = 64;
  localparam int unsigned DRAIN_CYC_DEF   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_TRAIN = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } fwd_state_e;

  // A phase of n cycles loads n-1 so that the counter reads 0 on its last cycle.
  function automatic logic [CNT_W-1:0] cyc_load(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/lvds_cyc_cnt.sv
// Loadable 16-bit down-counter with a zero flag; holds at zero instead of wrapping.
module lvds_cyc_cnt
  import lvds_fwd_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lvds_clk_fwd_ctrl.sv
// Sequencer for a forwarded LVDS clock: gated startup, training, run and drain,
// driving the ODDR2 clock-enable and lane-mode flags as pure Moore outputs.
module lvds_clk_fwd_ctrl
  import lvds_fwd_pkg::*;
#(
  parameter int unsigned STARTUP_CYC = STARTUP_CYC_DEF,
  parameter int unsigned TRAIN_CYC   = TRAIN_CYC_DEF,
  parameter int unsigned DRAIN_CYC   = DRAIN_CYC_DEF
) (
  input  logic       clk_lvds_sdr_in,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  output logic       clk_ce,
  output logic       train_en,
  output logic       link_ready,
  output logic       busy,
  output logic       stopped,
  output logic [2:0] state_o
);

  fwd_state_e       state_q;
  fwd_state_e       state_d;
  logic             stopped_q;
  logic             stopped_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;

  lvds_cyc_cnt u_cyc_cnt (
    .clk_i      (clk_lvds_sdr_in),
    .rst_ni     (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk_lvds_sdr_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      stopped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      stopped_q <= stopped_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (stop)          state_d = ST_IDLE;
        else if (cnt_zero) state_d = ST_TRAIN;
      end
      ST_TRAIN: begin
        if (stop)          state_d = ST_DRAIN;
        else if (cnt_zero) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cnt_zero) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter is reloaded on every state change so each timed phase starts fresh.
  always_comb begin
    cnt_load     = (state_d != state_q);
    cnt_load_val = '0;
    case (state_d)
      ST_WAIT:  cnt_load_val = cyc_load(STARTUP_CYC);
      ST_TRAIN: cnt_load_val = cyc_load(TRAIN_CYC);
      ST_DRAIN: cnt_load_val = cyc_load(DRAIN_CYC);
      default:  cnt_load_val = '0;
    endcase
    stopped_d = (state_q == ST_DRAIN) && (state_d == ST_IDLE);
  end

  always_comb begin
    clk_ce     = 1'b0;
    train_en   = 1'b0;
    link_ready = 1'b0;
    busy       = (state_q != ST_IDLE);
    stopped    = stopped_q;
    state_o    = state_q;
    case (state_q)
      ST_TRAIN: begin
        clk_ce   = 1'b1;
        train_en = 1'b1;
      end
      ST_RUN: begin
        clk_ce     = 1'b1;
        link_ready = 1'b1;
      end
      ST_DRAIN: clk_ce = 1'b1;
      default:  clk_ce = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_lvds_clk_fwd_ctrl.sv
// Directed bench for lvds_clk_fwd_ctrl: default-parameter instance plus a 1/1/1 instance.
module tb_lvds_clk_fwd_ctrl;

  // Output vector layout: {state[2:0], clk_ce, train_en, link_ready, busy, stopped}
  localparam logic [7:0] V_IDLE  = 8'b000_00000;
  localparam logic [7:0] V_STOP  = 8'b000_00001;
  localparam logic [7:0] V_WAIT  = 8'b001_00010;
  localparam logic [7:0] V_TRAIN = 8'b010_11010;
  localparam logic [7:0] V_RUN   = 8'b011_10110;
  localparam logic [7:0] V_DRAIN = 8'b100_10010;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, f_start, f_stop;
  logic       clk_ce, train_en, link_ready, busy, stopped;
  logic       f_clk_ce, f_train_en, f_link_ready, f_busy, f_stopped;
  logic [2:0] state_o, f_state_o;
  logic [7:0] vec, f_vec;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  assign vec   = {state_o, clk_ce, train_en, link_ready, busy, stopped};
  assign f_vec = {f_state_o, f_clk_ce, f_train_en, f_link_ready, f_busy, f_stopped};

  lvds_clk_fwd_ctrl dut (
    .clk_lvds_sdr_in (clk),
    .rst_n           (rst_n),
    .start           (start),
    .stop            (stop),
    .clk_ce          (clk_ce),
    .train_en        (train_en),
    .link_ready      (link_ready),
    .busy            (busy),
    .stopped         (stopped),
    .state_o         (state_o)
  );

  lvds_clk_fwd_ctrl #(
    .STARTUP_CYC (1),
    .TRAIN_CYC   (1),
    .DRAIN_CYC   (1)
  ) dut_fast (
    .clk_lvds_sdr_in (clk),
    .rst_n           (rst_n),
    .start           (f_start),
    .stop            (f_stop),
    .clk_ce          (f_clk_ce),
    .train_en        (f_train_en),
    .link_ready      (f_link_ready),
    .busy            (f_busy),
    .stopped         (f_stopped),
    .state_o         (f_state_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; f_start = 1'b0; f_stop = 1'b0;
    #1;
    tests++;
    if (vec !== V_IDLE) begin
      fails++; $display("FAIL reset_async got %b exp %b", vec, V_IDLE);
    end
    tests++;
    if (f_vec !== V_IDLE) begin
      fails++; $display("FAIL reset_async_fast got %b exp %b", f_vec, V_IDLE);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    tests++;
    if (vec !== V_IDLE) begin
      fails++; $display("FAIL reset_release_idle got %b exp %b", vec, V_IDLE);
    end
  endtask

  // Start pulse at cycle 0: WAIT 1..16, TRAIN 17..80, RUN at 81.
  task automatic test_startup();
    logic [7:0] exp;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 81; c++) begin
      exp = (c <= 16) ? V_WAIT : (c <= 80) ? V_TRAIN : V_RUN;
      tests++;
      if (vec !== exp) begin
        fails++; $display("FAIL startup cyc=%0d got %b exp %b", c, vec, exp);
      end
      if (c < 81) step();
    end
  endtask

  task automatic test_run_ignore_start();
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if (vec !== V_RUN) begin
        fails++; $display("FAIL run_ignore_start cyc=%0d got %b exp %b", c, vec, V_RUN);
      end
    end
    start = 1'b0;
  endtask

  // Stop stays high through DRAIN and IDLE to show it is ignored there.
  task automatic test_stop_drain();
    logic [7:0] exp;
    stop = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      exp = (c <= 8) ? V_DRAIN : (c == 9) ? V_STOP : V_IDLE;
      tests++;
      if (vec !== exp) begin
        fails++; $display("FAIL stop_drain cyc=%0d got %b exp %b", c, vec, exp);
      end
    end
    stop = 1'b0;
  endtask

  task automatic test_wait_abort();
    logic [7:0] exp;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      exp = (c <= 5) ? V_WAIT : V_IDLE;
      tests++;
      if (vec !== exp) begin
        fails++; $display("FAIL wait_abort cyc=%0d got %b exp %b", c, vec, exp);
      end
      stop = (c == 5);
      step();
    end
    stop = 1'b0;
  endtask

  task automatic test_both_idle();
    start = 1'b1; stop = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if (vec !== V_IDLE) begin
        fails++; $display("FAIL both_idle cyc=%0d got %b exp %b", c, vec, V_IDLE);
      end
    end
    start = 1'b0; stop = 1'b0;
    step();
  endtask

  task automatic test_train_abort();
    logic [7:0] exp;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      exp = (c <= 16) ? V_WAIT : (c <= 20) ? V_TRAIN : (c <= 28) ? V_DRAIN :
            (c == 29) ? V_STOP : V_IDLE;
      tests++;
      if (vec !== exp) begin
        fails++; $display("FAIL train_abort cyc=%0d got %b exp %b", c, vec, exp);
      end
      stop = (c == 20);
      step();
    end
    stop = 1'b0;
  endtask

  task automatic test_reset_mid_train();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (29) step();
    tests++;
    if (vec !== V_TRAIN) begin
      fails++; $display("FAIL pre_reset_train got %b exp %b", vec, V_TRAIN);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (vec !== V_IDLE) begin
      fails++; $display("FAIL reset_mid_train got %b exp %b", vec, V_IDLE);
    end
    step();
    tests++;
    if (vec !== V_IDLE) begin
      fails++; $display("FAIL reset_held got %b exp %b", vec, V_IDLE);
    end
    rst_n = 1'b1;
    test_startup();
  endtask

  // 1/1/1 instance, start held: WAIT and TRAIN one cycle each, restart after one-cycle DRAIN.
  task automatic test_fast();
    logic [7:0] exp_seq [1:10];
    exp_seq[1] = V_WAIT;  exp_seq[2] = V_TRAIN; exp_seq[3]  = V_RUN;
    exp_seq[4] = V_RUN;   exp_seq[5] = V_RUN;   exp_seq[6]  = V_DRAIN;
    exp_seq[7] = V_STOP;  exp_seq[8] = V_WAIT;  exp_seq[9]  = V_TRAIN;
    exp_seq[10] = V_RUN;
    f_start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      tests++;
      if (f_vec !== exp_seq[c]) begin
        fails++; $display("FAIL fast_cycle cyc=%0d got %b exp %b", c, f_vec, exp_seq[c]);
      end
      f_stop = (c == 5);
    end
    f_start = 1'b0;
    f_stop  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_run_ignore_start();
    test_stop_drain();
    test_wait_abort();
    test_both_idle();
    test_train_abort();
    test_reset_mid_train();
    test_stop_drain();
    test_fast();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
